switch_debouncer: RTL

- Input-side counterpart to the LED driver path: conditions WIDTH raw board inputs (push-buttons / DIP switches) for core logic.
- Per bit: 2-flop synchronizer, stability counter, debounced level, one-cycle rise/fall event pulses, sticky "pressed" flag cleared by software/core.
- Sits between board pins and control logic; all outputs registered, single clock domain.

---
 rtl/switch_debouncer.sv | 75 +++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Board-input conditioner: per-bit 2-flop synchronizer, stability-count debounce,
// registered rise/fall pulses, a sticky press flag and a combined event strobe.
module switch_debouncer #(
  parameter int               WIDTH         = 16,
  parameter int               STABLE_CYCLES = 5000000,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] db_level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] press_flag,
  output logic             any_event
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  // The counter is cleared on every update, so it can never pass CNT_LAST.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    level_next = db_level;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != db_level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_next[i] = sync2[i];
          rise_next[i]  = sync2[i];
          fall_next[i]  = ~sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= RESET_VAL;
      sync2      <= RESET_VAL;
      db_level   <= RESET_VAL;
      // NOTE: the counter array is small flop storage, not RAM, and must restart from zero after reset, so it is reset explicitly.
      cnt        <= '{default: '0};
      rise       <= '0;
      fall       <= '0;
      press_flag <= '0;
      any_event  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving a true two-stage synchronizer.
      sync1      <= raw_in;
      sync2      <= sync1;
      db_level   <= level_next;
      cnt        <= cnt_next;
      rise       <= rise_next;
      fall       <= fall_next;
      // A set on the update edge wins over a simultaneous clear.
      press_flag <= rise_next | (press_flag & ~flag_clr);
      any_event  <= |(rise_next | fall_next);
    end
  end

endmodule
